// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared constants and the bit-reversal helper for the FFT output reorder path.
package fft_bitrev_reorder_pkg;

  localparam int unsigned RB_N      = 16;
  localparam int unsigned RB_LOG2N  = 4;
  localparam int unsigned RB_DATA_W = 32;

  // Reverse the low `width` bits of idx; bits above width come back as zero.
  // Also used by the FFT twiddle control, hence the run-time width argument.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) r[5'(width - 1 - i)] = idx[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Input sample stream and natural-order output stream of the reorder buffer.
interface fft_bitrev_reorder_if
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int unsigned DATA_W = RB_DATA_W
);

  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  logic              in_valid;
  logic              in_sop;
  logic [DATA_W-1:0] out_real;
  logic [DATA_W-1:0] out_imag;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic              overrun;

  modport master (
    output in_real, in_imag, in_valid, in_sop, out_ready,
    input  out_real, out_imag, out_valid, out_sop, out_eop, overrun
  );

  modport slave (
    input  in_real, in_imag, in_valid, in_sop, out_ready,
    output out_real, out_imag, out_valid, out_sop, out_eop, overrun
  );

endinterface

// File: rtl/fft_bitrev_reorder_bitrev_bank.sv
// One frame of storage: flop array, synchronous write, combinational read.
module bitrev_bank #(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [N];

  // Store one sample; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read straight off the array so the output follows rcnt with no latency.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed FFT output, reads natural order.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int unsigned N      = RB_N,
  parameter int unsigned LOG2N  = RB_LOG2N,
  parameter int unsigned DATA_W = RB_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_bitrev_reorder_if.slave  bus
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0]    wcnt;
  logic [LOG2N-1:0]    rcnt;
  logic                wbank;
  logic                rbank;
  logic [1:0]          full;
  logic                ovr;

  logic [LOG2N-1:0]    widx;
  logic [LOG2N-1:0]    waddr;
  logic                rd_fire;
  logic                rd_last;
  logic                wr_ok;
  logic [1:0]          we;
  logic [2*DATA_W-1:0] wdata;
  logic [2*DATA_W-1:0] rdata0;
  logic [2*DATA_W-1:0] rdata1;
  logic [2*DATA_W-1:0] rdata;

  // Handshake decode; a bank freed by its last read this cycle may be written at once.
  always_comb begin
    rd_fire = full[rbank] & bus.out_ready;
    rd_last = rd_fire && (rcnt == LAST);
    wr_ok   = bus.in_valid && (!full[wbank] || (rd_last && (rbank == wbank)));
    widx    = bus.in_sop ? '0 : wcnt;
    waddr   = LOG2N'(bitrev(32'(widx), LOG2N));
    we[0]   = wr_ok && !wbank;
    we[1]   = wr_ok && wbank;
    wdata   = {bus.in_real, bus.in_imag};
  end

  bitrev_bank #(.N(N), .AW(LOG2N), .DW(2 * DATA_W)) u_bank0 (
    .clk   (clk),
    .we    (we[0]),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rcnt),
    .rdata (rdata0)
  );

  bitrev_bank #(.N(N), .AW(LOG2N), .DW(2 * DATA_W)) u_bank1 (
    .clk   (clk),
    .we    (we[1]),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rcnt),
    .rdata (rdata1)
  );

  // Counters, bank pointers and full flags.
  // The set of full[] is placed after the clear so a bank's own final write
  // wins if it coincides with the final read of that same bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt  <= '0;
      rcnt  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= '0;
      ovr   <= 1'b0;
    end else begin
      if (rd_fire) begin
        if (rcnt == LAST) begin
          rcnt        <= '0;
          rbank       <= ~rbank;
          full[rbank] <= 1'b0;
        end else begin
          rcnt <= rcnt + LOG2N'(1);
        end
      end
      if (wr_ok) begin
        if (widx == LAST) begin
          wcnt        <= '0;
          wbank       <= ~wbank;
          full[wbank] <= 1'b1;
        end else begin
          wcnt <= widx + LOG2N'(1);
        end
      end else if (bus.in_valid) begin
        ovr <= 1'b1;
      end
    end
  end

  // Output presentation, zeroed whenever the current read bank is empty.
  always_comb begin
    rdata         = rbank ? rdata1 : rdata0;
    bus.out_valid = full[rbank];
    bus.out_real  = bus.out_valid ? rdata[2*DATA_W-1:DATA_W] : '0;
    bus.out_imag  = bus.out_valid ? rdata[DATA_W-1:0] : '0;
    bus.out_sop   = bus.out_valid && (rcnt == '0);
    bus.out_eop   = bus.out_valid && (rcnt == LAST);
    bus.overrun   = ovr;
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the FFT bit-reversal reorder buffer.
module tb_fft_bitrev_reorder;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    int          idx;
  } exp_t;

  // Arrival order of natural indices for a 16-point bit-reversed frame.
  localparam int BRV [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   n_xfer;
  int   first_cyc;
  int   last_cyc;
  exp_t exp_q [$];

  fft_bitrev_reorder_if #(.DATA_W(32)) bus ();

  fft_bitrev_reorder #(.N(16), .LOG2N(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted output sample must match the next expected one.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_real", 64'(bus.out_real), 64'(e.re));
        check("out_imag", 64'(bus.out_imag), 64'(e.im));
        check("out_sop", 64'(bus.out_sop), 64'(e.idx == 0));
        check("out_eop", 64'(bus.out_eop), 64'(e.idx == 15));
      end
      if (n_xfer == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_xfer++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [31:0] base);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back('{re: base + 32'(k), im: base + 32'(k) + 32'h100, idx: k});
    end
  endtask

  task automatic send_frame(input logic [31:0] base, input bit lat);
    for (int i = 0; i < 16; i++) begin
      bus.in_real  = base + 32'(BRV[i]);
      bus.in_imag  = base + 32'(BRV[i]) + 32'h100;
      bus.in_valid = 1'b1;
      bus.in_sop   = (i == 0);
      if (lat && i == 15) check("lat_pre_valid", 64'(bus.out_valid), 64'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    if (lat) begin
      check("lat_post_valid", 64'(bus.out_valid), 64'd1);
      check("lat_first_real", 64'(bus.out_real), 64'(base));
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    exp_q.delete();
    rst = 1'b1;
    tick();
  endtask

  task automatic new_test;
    n_xfer    = 0;
    first_cyc = 0;
    last_cyc  = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    new_test();
    rst           = 1'b1;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.in_valid  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_real", 64'(bus.out_real), 64'd0);
    check("rst_imag", 64'(bus.out_imag), 64'd0);
    check("rst_sop", 64'(bus.out_sop), 64'd0);
    check("rst_eop", 64'(bus.out_eop), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single frame with latency check.
    new_test();
    bus.out_ready = 1'b1;
    expect_frame(32'h0);
    send_frame(32'h0, 1'b1);
    wait_drain(40);
    check("t1_count", 64'(n_xfer), 64'd16);
    check("t1_span", 64'(last_cyc - first_cyc), 64'd15);

    // Three back-to-back frames, no output gaps.
    new_test();
    expect_frame(32'h1000);
    expect_frame(32'h2000);
    expect_frame(32'h3000);
    send_frame(32'h1000, 1'b0);
    send_frame(32'h2000, 1'b0);
    send_frame(32'h3000, 1'b0);
    wait_drain(60);
    check("t2_count", 64'(n_xfer), 64'd48);
    check("t2_span", 64'(last_cyc - first_cyc), 64'd47);
    check("t2_overrun", 64'(bus.overrun), 64'd0);

    // Consumer stalled: two frames stored, third overruns.
    new_test();
    bus.out_ready = 1'b0;
    expect_frame(32'h4000);
    expect_frame(32'h5000);
    send_frame(32'h4000, 1'b0);
    send_frame(32'h5000, 1'b0);
    check("t3_ovr_before", 64'(bus.overrun), 64'd0);
    send_frame(32'h6000, 1'b0);
    check("t3_ovr_after", 64'(bus.overrun), 64'd1);
    check("t3_held_valid", 64'(bus.out_valid), 64'd1);
    check("t3_held_real", 64'(bus.out_real), 64'h4000);
    bus.out_ready = 1'b1;
    wait_drain(60);
    check("t3_count", 64'(n_xfer), 64'd32);
    check("t3_valid_after", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a drain, overrun still set from before.
    new_test();
    expect_frame(32'h7000);
    send_frame(32'h7000, 1'b0);
    for (int c = 0; c < 40 && n_xfer < 7; c++) tick();
    check("t4_mid_xfer", 64'(n_xfer), 64'd7);
    check("t4_pre_real", 64'(bus.out_real), 64'h7007);
    rst = 1'b0;
    #1;
    check("t4_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t4_rst_real", 64'(bus.out_real), 64'd0);
    check("t4_rst_imag", 64'(bus.out_imag), 64'd0);
    check("t4_rst_overrun", 64'(bus.overrun), 64'd0);
    tick();
    exp_q.delete();
    rst = 1'b1;
    tick();
    new_test();
    expect_frame(32'h8000);
    send_frame(32'h8000, 1'b1);
    wait_drain(40);
    check("t4_count", 64'(n_xfer), 64'd16);

    // Ready toggling mid-frame: held values, no skip or duplicate.
    new_test();
    bus.out_ready = 1'b0;
    expect_frame(32'h9000);
    send_frame(32'h9000, 1'b0);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      bus.out_ready = (c >= 4 && c < 12) ? (c % 2 == 0) : 1'b1;
      if (!bus.out_ready && bus.out_valid) begin
        check("t5_hold_real", 64'(bus.out_real), 64'(exp_q[0].re));
        check("t5_hold_imag", 64'(bus.out_imag), 64'(exp_q[0].im));
      end
      tick();
    end
    check("t5_drain_left", 64'(exp_q.size()), 64'd0);
    check("t5_count", 64'(n_xfer), 64'd16);
    bus.out_ready = 1'b1;

    // Restart via in_sop at arrival index 5: partial frame discarded.
    new_test();
    for (int i = 0; i < 5; i++) begin
      bus.in_real  = 32'hDEAD0000 + 32'(i);
      bus.in_imag  = 32'hBEEF0000 + 32'(i);
      bus.in_valid = 1'b1;
      bus.in_sop   = (i == 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    check("t6_no_valid", 64'(bus.out_valid), 64'd0);
    expect_frame(32'hA000);
    send_frame(32'hA000, 1'b1);
    wait_drain(40);
    check("t6_count", 64'(n_xfer), 64'd16);
    check("t6_overrun", 64'(bus.overrun), 64'd0);

    do_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-side reader for the 16-point pipelined FFT.
- The FFT emits one complex float32 sample per cycle in bit-reversed index order. This block buffers each frame and re-emits it in natural order (X[0]..X[N-1]).
- Ping-pong double buffer: one bank fills while the other drains, so continuous input frames are sustained when the consumer keeps up.
- Downstream interface is valid/ready with backpressure.

Parameters:
- N, 16, points per frame (power of two).
- LOG2N, 4, index width (log2 N).
- DATA_W, 32, width of each real/imag word (IEEE-754 single, matches `BITS_RANGE).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_real  in  DATA_W  FFT output, real part.
- in_imag  in  DATA_W  FFT output, imaginary part.
- in_valid  in  1  sample present this cycle.
- in_sop  in  1  first sample of a frame; qualified by in_valid.
- out_real  out  DATA_W  natural-order real part.
- out_imag  out  DATA_W  natural-order imaginary part.
- out_valid  out  1  output sample present.
- out_ready  in  1  consumer accepts the sample.
- out_sop  out  1  out_valid and natural index 0.
- out_eop  out  1  out_valid and natural index N-1.
- overrun  out  1  sticky: an input sample was dropped.

Behaviour:
- Reset (rst=0, asynchronous): wcnt=0, rcnt=0, wbank=0, rbank=0, full[1:0]=0, overrun=0. All outputs 0. Bank storage is not reset.
- Write side:
  - A sample is accepted when in_valid=1 and (full[wbank]=0, or the read side completes its final transfer from bank wbank this same cycle).
  - An accepted sample is stored at address bitrev(wcnt) in bank wbank, and wcnt increments.
  - in_sop=1 on an accepted sample forces the write address to bitrev(0) and sets wcnt to 1. Any partial frame is discarded, with no flag.
  - Accepted write with wcnt=N-1: set full[wbank], toggle wbank, wrap wcnt to 0.
  - If in_valid=1 but the sample is not accepted: drop it, wcnt holds, overrun becomes 1 until reset.
- Read side:
  - out_valid = full[rbank].
  - out_real/out_imag = bank[rbank][rcnt] when out_valid=1, else 0.
  - Output data comes combinationally from the flop array; there is no output register.
  - Transfer occurs when out_valid and out_ready are both 1; rcnt then increments.
  - Transfer at rcnt=N-1: clear full[rbank], toggle rbank, wrap rcnt to 0.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- Latency: last input sample written at edge E, so out_valid=1 in the cycle after E. Index 0 is presented first.
- Simultaneous events:
  - Setting full on one bank and clearing full on the other bank in the same cycle are independent.
  - Write into a bank whose last read completes that cycle is allowed; full stays cleared until that bank's own final write.
- Throughput: 1 sample/cycle sustained with out_ready=1. Input stalls (in_valid gaps) are tolerated anywhere in a frame.
- Mid-operation reset: everything returns to reset values immediately; partial frames are lost.

Decomposition:
- params.v: add RB_N, RB_LOG2N, and a shared bitrev function of width LOG2N (also usable by FFT twiddle control). Reuse `BITS_RANGE and `NUM0.
- Sub-module bitrev_bank: N x (2*DATA_W) flop array with one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata). Instantiate twice, once per bank.

Test Plan:
- Single frame, input values in arrival order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 (real=value, imag=value+32'h100), out_ready=1:
  - out_real must read 0..15 and out_imag 32'h100..32'h10F on 16 consecutive cycles.
  - out_valid must rise one cycle after the 16th input.
  - out_sop on the first output only, out_eop on the last only.
- Three back-to-back frames with out_ready=1: no gaps at the output, overrun stays 0, and each frame is independently correct.
- out_ready=0 held throughout while 3 frames are sent:
  - frames 1 and 2 are stored;
  - the first sample of frame 3 sets overrun=1;
  - releasing out_ready then drains frames 1 and 2 intact.
- out_ready toggling 1,0,1,0 mid-frame: values hold while ready=0, with no duplicated or skipped index.
- in_sop asserted at arrival index 5 of a frame, followed by a full 16-sample frame: only the restarted frame is output, correct, overrun=0.
- rst pulsed low mid-drain at rcnt=7: out_valid=0, outputs 0, overrun=0 immediately. A subsequent single frame outputs correctly.
